// File: rtl/quad_disp_pkg.sv
// Shared types and the hex-to-segment table for the multiplexed seven-segment display.
package quad_disp_pkg;

    // Segment vector ordered {g,f,e,d,c,b,a}; always active-high inside the design.
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_OFF = 7'h00;

    // Active-high patterns for 0-9, A, b, C, d, E, F. No entry is all-off.
    localparam seg7_t HEX_SEG7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } slot_state_e;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble -> seven-segment decode, active-high.
module seg7_hex_decoder
    import quad_disp_pkg::*;
(
    input  logic [3:0] i_nib,
    output seg7_t      o_seg
);

    assign o_seg = HEX_SEG7[i_nib];

endmodule

// File: rtl/quad_disp_scanner.sv
// Eight-digit multiplexed seven-segment scanner with per-slot blanking gap.
// The displayed word is latched once per scan so digits never tear mid-frame.
// Optional build macro QUAD_DISP_LZ_SUPPRESS_EN: darken leading-zero digits.
module quad_disp_scanner
    import quad_disp_pkg::*;
#(
    parameter int NUM_DIGITS          = 8,
    parameter int DIGIT_PERIOD_CYCLES = 50000,
    parameter int BLANK_CYCLES        = 500,
    parameter int ACTIVE_LOW          = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_digit_en,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    output logic [NUM_DIGITS-1:0]   o_anode,
    output logic [6:0]              o_seg,
    output logic                    o_dp
);

    localparam int CNT_W = $clog2(DIGIT_PERIOD_CYCLES);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam slot_state_e      ST_RESET  = (BLANK_CYCLES > 0) ? ST_BLANK : ST_ON;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    slot_state_e             state_q, state_d;
    logic [4*NUM_DIGITS-1:0] snap_value_q, snap_value_d;
    logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    seg7_t                   seg_q, seg_d;
    logic                    dp_q, dp_d;

    logic                    scan_start;
    logic [NUM_DIGITS-1:0]   vis_en;
    logic [3:0]              nib;
    logic                    lit;
    seg7_t                   dec_seg;

    seg7_hex_decoder u_dec (
        .i_nib (nib),
        .o_seg (dec_seg)
    );

    // Slot/digit sequencing, snapshot capture and next output image.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        state_d = (cnt_d < BLANK_END) ? ST_BLANK : ST_ON;

        // The snapshot is bypassed on its capture cycle so the first slot of a
        // scan already sees the new word even with no blanking gap.
        scan_start   = (cnt_q == '0) && (idx_q == '0);
        snap_value_d = scan_start ? i_value    : snap_value_q;
        snap_en_d    = scan_start ? i_digit_en : snap_en_q;
        snap_dp_d    = scan_start ? i_dp       : snap_dp_q;

`ifdef QUAD_DISP_LZ_SUPPRESS_EN
        // A digit stays eligible if it or any higher enabled digit is nonzero.
        begin
            logic found;
            found     = 1'b0;
            vis_en    = '0;
            vis_en[0] = snap_en_d[0];
            for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
                if (snap_en_d[k] && (snap_value_d[4*k +: 4] != 4'h0)) found = 1'b1;
                vis_en[k] = snap_en_d[k] & found;
            end
        end
`else
        vis_en = snap_en_d;
`endif

        nib     = snap_value_d[{idx_q, 2'b00} +: 4];
        lit     = (state_q == ST_ON) && vis_en[idx_q];
        anode_d = '0;
        seg_d   = SEG7_OFF;
        dp_d    = 1'b0;
        if (lit) begin
            anode_d[idx_q] = 1'b1;
            seg_d          = dec_seg;
            dp_d           = snap_dp_d[idx_q];
        end
    end

    // State, snapshot and output registers; reset restarts the scan at digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            state_q      <= ST_RESET;
            snap_value_q <= '0;
            snap_en_q    <= '0;
            snap_dp_q    <= '0;
            anode_q      <= '0;
            seg_q        <= SEG7_OFF;
            dp_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            snap_value_q <= snap_value_d;
            snap_en_q    <= snap_en_d;
            snap_dp_q    <= snap_dp_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    // Board polarity is applied only to the registered image.
    assign o_anode = (ACTIVE_LOW != 0) ? ~anode_q : anode_q;
    assign o_seg   = (ACTIVE_LOW != 0) ? ~seg_q   : seg_q;
    assign o_dp    = (ACTIVE_LOW != 0) ? ~dp_q    : dp_q;

endmodule

// File: tb/tb_quad_disp_scanner.sv
// Directed bench for quad_disp_scanner (8 digits, 8-cycle slots, 2 blank cycles, active-low).
// Honors QUAD_DISP_LZ_SUPPRESS_EN for the leading-zero expectations.
module tb_quad_disp_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_value;
    logic [7:0]  i_digit_en;
    logic [7:0]  i_dp;
    logic [7:0]  o_anode;
    logic [6:0]  o_seg;
    logic        o_dp;

    int n_chk  = 0;
    int n_fail = 0;

    quad_disp_scanner #(
        .NUM_DIGITS          (8),
        .DIGIT_PERIOD_CYCLES (8),
        .BLANK_CYCLES        (2),
        .ACTIVE_LOW          (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_value    (i_value),
        .i_digit_en (i_digit_en),
        .i_dp       (i_dp),
        .o_anode    (o_anode),
        .o_seg      (o_seg),
        .o_dp       (o_dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_off(input string tag);
        chk({tag, "_an"}, {24'b0, o_anode}, 32'hFF);
        chk({tag, "_seg"}, {25'b0, o_seg}, 32'h7F);
        chk({tag, "_dp"}, {31'b0, o_dp}, 32'h1);
    endtask

    // Called when the outputs show slot 0 of digit 0; checks one whole scan.
    // At digit chg_d (slot 0) new inputs are applied; they belong to the next scan.
    task automatic scan_check(input string tag, input logic [7:0][6:0] segs,
                              input logic [7:0] en, input logic [7:0] dp, input int chg_d,
                              input logic [31:0] nv, input logic [7:0] nen, input logic [7:0] ndp);
        logic [7:0] ea;
        logic [6:0] es;
        logic       ed;
        logic       on;
        int         lows;
        for (int d = 0; d < 8; d++) begin
            lows = 0;
            for (int c = 0; c < 8; c++) begin
                if (c == 0 && d == chg_d) begin
                    i_value    = nv;
                    i_digit_en = nen;
                    i_dp       = ndp;
                end
                on = (c >= 2) && en[d];
                ea = on ? ~(8'b1 << d) : 8'hFF;
                es = on ? segs[d] : 7'h7F;
                ed = on ? ~dp[d] : 1'b1;
                chk($sformatf("%s_d%0d_c%0d_an", tag, d, c), {24'b0, o_anode}, {24'b0, ea});
                chk($sformatf("%s_d%0d_c%0d_seg", tag, d, c), {25'b0, o_seg}, {25'b0, es});
                chk($sformatf("%s_d%0d_c%0d_dp", tag, d, c), {31'b0, o_dp}, {31'b0, ed});
                if (o_anode[d] == 1'b0) lows++;
                tick();
            end
            chk($sformatf("%s_d%0d_lowcnt", tag, d), lows, en[d] ? 6 : 0);
        end
    endtask

    logic [7:0] lz_en42;
    logic [7:0] lz_en0;

    initial begin
`ifdef QUAD_DISP_LZ_SUPPRESS_EN
        lz_en42 = 8'h03;
        lz_en0  = 8'h01;
`else
        lz_en42 = 8'hFF;
        lz_en0  = 8'hFF;
`endif
        // Reset held for three edges; first scan word is set up before release.
        rst        = 1'b1;
        i_value    = 32'h0123_ABCD;
        i_digit_en = 8'hFF;
        i_dp       = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_off($sformatf("rst_hold%0d", k));
        end
        rst = 1'b0;
        chk_off("rel_c1");
        tick();

        // Decode of 0123ABCD: d,C,b,A,3,2,1,0 on digits 0..7.
        scan_check("dec", {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21},
                   8'hFF, 8'h00, 0, 32'h1111_1111, 8'hFF, 8'h00);
        // Word changes to 2222_2222 while digit 3 shows; the rest of the scan stays '1'.
        scan_check("tear1", {8{7'h79}}, 8'hFF, 8'h00, 3, 32'h2222_2222, 8'hFF, 8'h00);
        scan_check("tear2", {8{7'h24}}, 8'hFF, 8'h00, 0, 32'h8765_4321, 8'h0F, 8'h01);
        // Upper digits disabled, decimal point only on digit 0.
        scan_check("en_dp", {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79},
                   8'h0F, 8'h01, 0, 32'h8765_4321, 8'hFF, 8'h00);

        // Advance to the point where the counter is at digit 5, slot 4.
        for (int k = 0; k < 43; k++) tick();
        chk("pre_rst_an", {24'b0, o_anode}, 32'hDF);
        chk("pre_rst_seg", {25'b0, o_seg}, 32'h02);
        rst = 1'b1;
        tick();
        chk_off("mid_rst");
        i_value    = 32'h0000_0042;
        i_digit_en = 8'hFF;
        i_dp       = 8'h00;
        tick();
        chk_off("mid_rst2");
        rst = 1'b0;
        chk_off("mid_rel");
        tick();

        scan_check("lz42", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24},
                   lz_en42, 8'h00, 0, 32'h0000_0000, 8'hFF, 8'h00);
        scan_check("lz0", {8{7'h40}}, lz_en0, 8'h00, 8, 32'h0, 8'h0, 8'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
